// File: rtl/multicycle_control.sv
// Multi-cycle MIPS control FSM: sequences IF/ID/EXE/MEM/WB, waits on memReady, counts retires.
// Optional illegal-instruction trap to HALT is enabled by defining MC_CTRL_ILLEGAL_TRAP_EN.
module multicycle_control #(
  parameter int unsigned CNT_W      = 32,
  parameter bit          USE_MEM_HS = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       OP,
  input  logic [5:0]       funct,
  input  logic             zero,
  input  logic             memReady,
  output logic             irWrite,
  output logic             pcWrite,
  output logic [1:0]       pcSrc,
  output logic             memRead,
  output logic             memWrite,
  output logic             memToReg,
  output logic             ALUsrc,
  output logic             regWrite,
  output logic             regDst,
  output logic             extop,
  output logic [2:0]       ALUctr,
  output logic [2:0]       state,
  output logic             instrDone,
  output logic [CNT_W-1:0] instret,
  output logic             illegal
);

  typedef enum logic [2:0] {
    StIf   = 3'd0,
    StId   = 3'd1,
    StExe  = 3'd2,
    StMem  = 3'd3,
    StWb   = 3'd4,
    StHalt = 3'd5
  } state_e;

  localparam logic [5:0] OpR   = 6'b000000;
  localparam logic [5:0] OpJ   = 6'b000010;
  localparam logic [5:0] OpBeq = 6'b000100;
  localparam logic [5:0] OpOri = 6'b001101;
  localparam logic [5:0] OpLw  = 6'b100011;
  localparam logic [5:0] OpSw  = 6'b101011;

  localparam logic [2:0] AluAnd = 3'b000;
  localparam logic [2:0] AluOr  = 3'b001;
  localparam logic [2:0] AluAdd = 3'b010;
  localparam logic [2:0] AluSub = 3'b110;
  localparam logic [2:0] AluSlt = 3'b111;

  state_e           state_q, state_d;
  logic [5:0]       op_q, funct_q;
  logic [CNT_W-1:0] instret_q;
  logic             ir_load;
  logic             mem_rdy;
  logic [2:0]       r_alu;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
  logic             funct_ok;
`endif

  assign mem_rdy = USE_MEM_HS ? memReady : 1'b1;

  // R-type funct decode; unknown codes fall back to ADD
  always_comb begin
    r_alu = AluAdd;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    funct_ok = 1'b1;
`endif
    case (funct_q)
      6'b100000: r_alu = AluAdd;
      6'b100010: r_alu = AluSub;
      6'b100100: r_alu = AluAnd;
      6'b100101: r_alu = AluOr;
      6'b101010: r_alu = AluSlt;
      default: begin
        r_alu = AluAdd;
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        funct_ok = 1'b0;
`endif
      end
    endcase
  end

  always_comb begin
    state_d   = state_q;
    ir_load   = 1'b0;
    irWrite   = 1'b0;
    pcWrite   = 1'b0;
    pcSrc     = 2'b00;
    memRead   = 1'b0;
    memWrite  = 1'b0;
    memToReg  = 1'b0;
    ALUsrc    = 1'b0;
    regWrite  = 1'b0;
    regDst    = 1'b0;
    extop     = 1'b0;
    ALUctr    = 3'b000;
    instrDone = 1'b0;
    illegal   = 1'b0;

    // ALU controls stay asserted through MEM and WB so address/result are stable
    if (state_q == StExe || state_q == StMem || state_q == StWb) begin
      case (op_q)
        OpR:       begin ALUsrc = 1'b0; ALUctr = r_alu; end
        OpOri:     begin ALUsrc = 1'b1; ALUctr = AluOr; end
        OpLw, OpSw: begin ALUsrc = 1'b1; extop = 1'b1; ALUctr = AluAdd; end
        OpBeq:     begin ALUsrc = 1'b0; extop = 1'b1; ALUctr = AluSub; end
        default:   ;
      endcase
    end

    unique case (state_q)
      StIf: begin
        memRead = 1'b1;
        if (mem_rdy) begin
          irWrite = 1'b1;
          pcWrite = 1'b1;
          ir_load = 1'b1;
          state_d = StId;
        end
      end
      StId: begin
        case (op_q)
          OpJ: begin
            pcWrite   = 1'b1;
            pcSrc     = 2'b10;
            instrDone = 1'b1;
            state_d   = StIf;
          end
          OpR, OpOri, OpLw, OpSw, OpBeq: state_d = StExe;
          default: begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            state_d = StHalt;
`else
            instrDone = 1'b1;
            state_d   = StIf;
`endif
          end
        endcase
      end
      StExe: begin
        case (op_q)
          OpR: begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
            state_d = funct_ok ? StWb : StHalt;
`else
            state_d = StWb;
`endif
          end
          OpOri:      state_d = StWb;
          OpLw, OpSw: state_d = StMem;
          OpBeq: begin
            pcWrite   = zero;
            pcSrc     = 2'b01;
            instrDone = 1'b1;
            state_d   = StIf;
          end
          default:    state_d = StIf;
        endcase
      end
      StMem: begin
        case (op_q)
          OpLw: begin
            memRead = 1'b1;
            if (mem_rdy) state_d = StWb;
          end
          OpSw: begin
            memWrite = 1'b1;
            if (mem_rdy) begin
              instrDone = 1'b1;
              state_d   = StIf;
            end
          end
          default: if (mem_rdy) state_d = StIf;
        endcase
      end
      StWb: begin
        regWrite  = 1'b1;
        regDst    = (op_q == OpR);
        memToReg  = (op_q == OpLw);
        instrDone = 1'b1;
        state_d   = StIf;
      end
      StHalt: begin
`ifdef MC_CTRL_ILLEGAL_TRAP_EN
        illegal = 1'b1;
`else
        state_d = StIf;
`endif
      end
      default: state_d = StIf;
    endcase

    // Reset cycle suppresses every strobe, including a pending write
    if (rst) begin
      ir_load   = 1'b0;
      irWrite   = 1'b0;
      pcWrite   = 1'b0;
      pcSrc     = 2'b00;
      memRead   = 1'b0;
      memWrite  = 1'b0;
      memToReg  = 1'b0;
      ALUsrc    = 1'b0;
      regWrite  = 1'b0;
      regDst    = 1'b0;
      extop     = 1'b0;
      ALUctr    = 3'b000;
      instrDone = 1'b0;
      illegal   = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIf;
      op_q      <= '0;
      funct_q   <= '0;
      instret_q <= '0;
    end else begin
      state_q <= state_d;
      if (ir_load) begin
        op_q    <= OP;
        funct_q <= funct;
      end
      if (instrDone) instret_q <= instret_q + CNT_W'(1);
    end
  end

  assign state   = state_q;
  assign instret = instret_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: per-cycle expected control vectors go through a
// scoreboard queue and are checked at the falling edge; instret is tracked by a bench model.
module tb_multicycle_control;

  localparam int unsigned CntW = 4;

  logic            clk = 1'b0;
  logic            rst;
  logic [5:0]      OP, funct;
  logic            zero, memReady;
  logic            irWrite, pcWrite, memRead, memWrite, memToReg;
  logic            ALUsrc, regWrite, regDst, extop, instrDone, illegal;
  logic [1:0]      pcSrc;
  logic [2:0]      ALUctr, state;
  logic [CntW-1:0] instret;

  multicycle_control #(.CNT_W(CntW), .USE_MEM_HS(1'b1)) dut (
    .clk(clk), .rst(rst), .OP(OP), .funct(funct), .zero(zero), .memReady(memReady),
    .irWrite(irWrite), .pcWrite(pcWrite), .pcSrc(pcSrc), .memRead(memRead),
    .memWrite(memWrite), .memToReg(memToReg), .ALUsrc(ALUsrc), .regWrite(regWrite),
    .regDst(regDst), .extop(extop), .ALUctr(ALUctr), .state(state),
    .instrDone(instrDone), .instret(instret), .illegal(illegal)
  );

  always #5 clk = ~clk;

  // {state, irWrite, pcWrite, pcSrc, memRead, memWrite, memToReg, ALUsrc, regWrite, regDst,
  //  extop, ALUctr, instrDone, illegal}
  logic [18:0] obs;
  assign obs = {state, irWrite, pcWrite, pcSrc, memRead, memWrite, memToReg, ALUsrc,
                regWrite, regDst, extop, ALUctr, instrDone, illegal};

  localparam logic [18:0] SIf   = 19'(0) << 16;
  localparam logic [18:0] SId   = 19'(1) << 16;
  localparam logic [18:0] SExe  = 19'(2) << 16;
  localparam logic [18:0] SMem  = 19'(3) << 16;
  localparam logic [18:0] SWb   = 19'(4) << 16;
  localparam logic [18:0] SHalt = 19'(5) << 16;
  localparam logic [18:0] CIrw  = 19'(1) << 15;
  localparam logic [18:0] CPcw  = 19'(1) << 14;
  localparam logic [18:0] CPcBr = 19'(1) << 12;
  localparam logic [18:0] CPcJ  = 19'(2) << 12;
  localparam logic [18:0] CMrd  = 19'(1) << 11;
  localparam logic [18:0] CMwr  = 19'(1) << 10;
  localparam logic [18:0] CM2r  = 19'(1) << 9;
  localparam logic [18:0] CAsrc = 19'(1) << 8;
  localparam logic [18:0] CRw   = 19'(1) << 7;
  localparam logic [18:0] CRd   = 19'(1) << 6;
  localparam logic [18:0] CExt  = 19'(1) << 5;
  localparam logic [18:0] AOr   = 19'(1) << 2;
  localparam logic [18:0] AAdd  = 19'(2) << 2;
  localparam logic [18:0] ASub  = 19'(6) << 2;
  localparam logic [18:0] ASlt  = 19'(7) << 2;
  localparam logic [18:0] CDone = 19'(1) << 1;
  localparam logic [18:0] CIll  = 19'(1);
  localparam logic [18:0] Fetch = SIf | CIrw | CPcw | CMrd;

  logic [18:0]     sb[$];
  logic [18:0]     ev_pop;
  logic [CntW-1:0] exp_cnt = '0;
  int              checks = 0;
  int              fails = 0;

  task automatic set_instr(input logic [5:0] op, input logic [5:0] f);
    OP = op;
    funct = f;
  endtask

  task automatic step(input string tag, input logic r, input logic mr, input logic z,
                      input logic [18:0] ev);
    rst = r;
    memReady = mr;
    zero = z;
    sb.push_back(ev);
    @(negedge clk);
    ev_pop = sb.pop_front();
    checks++;
    assert (obs === ev_pop) else begin
      fails++;
      $error("FAIL %s ctl: observed %05h expected %05h", tag, obs, ev_pop);
    end
    checks++;
    assert (instret === exp_cnt) else begin
      fails++;
      $error("FAIL %s instret: observed %0d expected %0d", tag, instret, exp_cnt);
    end
    if (r) exp_cnt = '0;
    else if (ev_pop[1]) exp_cnt = exp_cnt + 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; memReady = 1'b0; zero = 1'b0;
    set_instr(6'b000000, 6'b100000);
    step("reset", 1'b1, 1'b0, 1'b0, SIf);
    step("reset2", 1'b1, 1'b1, 1'b0, SIf);

    // R-type ADD: IF, ID, EXE, WB
    step("add_if", 1'b0, 1'b1, 1'b0, Fetch);
    step("add_id", 1'b0, 1'b1, 1'b0, SId);
    step("add_exe", 1'b0, 1'b1, 1'b0, SExe | AAdd);
    step("add_wb", 1'b0, 1'b1, 1'b0, SWb | CRw | CRd | AAdd | CDone);

    set_instr(6'b000000, 6'b101010);
    step("slt_if", 1'b0, 1'b1, 1'b0, Fetch);
    set_instr(6'b111111, 6'b111111);  // fetched fields must already be latched
    step("slt_id", 1'b0, 1'b1, 1'b0, SId);
    step("slt_exe", 1'b0, 1'b0, 1'b0, SExe | ASlt);
    step("slt_wb", 1'b0, 1'b0, 1'b0, SWb | CRw | CRd | ASlt | CDone);

    // LW with two wait cycles in MEM
    set_instr(6'b100011, 6'b000000);
    step("lw_if", 1'b0, 1'b1, 1'b0, Fetch);
    step("lw_id", 1'b0, 1'b1, 1'b0, SId);
    step("lw_exe", 1'b0, 1'b1, 1'b0, SExe | CAsrc | CExt | AAdd);
    step("lw_mem0", 1'b0, 1'b0, 1'b0, SMem | CMrd | CAsrc | CExt | AAdd);
    step("lw_mem1", 1'b0, 1'b0, 1'b0, SMem | CMrd | CAsrc | CExt | AAdd);
    step("lw_mem2", 1'b0, 1'b1, 1'b0, SMem | CMrd | CAsrc | CExt | AAdd);
    step("lw_wb", 1'b0, 1'b1, 1'b0, SWb | CRw | CM2r | CAsrc | CExt | AAdd | CDone);

    // BEQ taken, then not taken
    set_instr(6'b000100, 6'b000000);
    step("beq1_if", 1'b0, 1'b1, 1'b0, Fetch);
    step("beq1_id", 1'b0, 1'b1, 1'b1, SId);
    step("beq1_exe", 1'b0, 1'b1, 1'b1, SExe | CPcw | CPcBr | CExt | ASub | CDone);
    step("beq0_if", 1'b0, 1'b1, 1'b0, Fetch);
    step("beq0_id", 1'b0, 1'b1, 1'b0, SId);
    step("beq0_exe", 1'b0, 1'b1, 1'b0, SExe | CPcBr | CExt | ASub | CDone);

    // J
    set_instr(6'b000010, 6'b000000);
    step("j_if", 1'b0, 1'b1, 1'b0, Fetch);
    step("j_id", 1'b0, 1'b0, 1'b0, SId | CPcw | CPcJ | CDone);

    // ORI with one wait cycle in IF; stray memReady outside IF/MEM
    set_instr(6'b001101, 6'b000000);
    step("ori_ifw", 1'b0, 1'b0, 1'b0, SIf | CMrd);
    step("ori_if", 1'b0, 1'b1, 1'b0, Fetch);
    step("ori_id", 1'b0, 1'b1, 1'b0, SId);
    step("ori_exe", 1'b0, 1'b1, 1'b0, SExe | CAsrc | AOr);
    step("ori_wb", 1'b0, 1'b0, 1'b0, SWb | CRw | CAsrc | AOr | CDone);

    // SW abandoned by reset in MEM
    set_instr(6'b101011, 6'b000000);
    step("swr_if", 1'b0, 1'b1, 1'b0, Fetch);
    step("swr_id", 1'b0, 1'b1, 1'b0, SId);
    step("swr_exe", 1'b0, 1'b1, 1'b0, SExe | CAsrc | CExt | AAdd);
    step("swr_mem", 1'b1, 1'b1, 1'b0, SMem);
    step("sw_if", 1'b0, 1'b1, 1'b0, Fetch);
    step("sw_id", 1'b0, 1'b1, 1'b0, SId);
    step("sw_exe", 1'b0, 1'b1, 1'b0, SExe | CAsrc | CExt | AAdd);
    step("sw_mem", 1'b0, 1'b1, 1'b0, SMem | CMwr | CAsrc | CExt | AAdd | CDone);

`ifdef MC_CTRL_ILLEGAL_TRAP_EN
    set_instr(6'b111111, 6'b000000);
    step("ill_if", 1'b0, 1'b1, 1'b0, Fetch);
    step("ill_id", 1'b0, 1'b1, 1'b0, SId);
    step("ill_halt0", 1'b0, 1'b1, 1'b0, SHalt | CIll);
    step("ill_halt1", 1'b0, 1'b0, 1'b0, SHalt | CIll);
    step("ill_rst", 1'b1, 1'b1, 1'b0, SHalt);
    set_instr(6'b000000, 6'b111111);
    step("badf_if", 1'b0, 1'b1, 1'b0, Fetch);
    step("badf_id", 1'b0, 1'b1, 1'b0, SId);
    step("badf_exe", 1'b0, 1'b1, 1'b0, SExe | AAdd);
    step("badf_halt", 1'b0, 1'b1, 1'b0, SHalt | CIll);
`else
    set_instr(6'b111111, 6'b000000);
    step("ill_if", 1'b0, 1'b1, 1'b0, Fetch);
    step("ill_id", 1'b0, 1'b1, 1'b0, SId | CDone);
    set_instr(6'b000000, 6'b111111);
    step("badf_if", 1'b0, 1'b1, 1'b0, Fetch);
    step("badf_id", 1'b0, 1'b1, 1'b0, SId);
    step("badf_exe", 1'b0, 1'b1, 1'b0, SExe | AAdd);
    step("badf_wb", 1'b0, 1'b1, 1'b0, SWb | CRw | CRd | AAdd | CDone);
`endif
    step("pre_wrap_rst", 1'b1, 1'b1, 1'b0, 19'(state) << 16);

    // 16 jumps wrap a 4-bit counter back to 0
    set_instr(6'b000010, 6'b000000);
    for (int i = 0; i < 16; i++) begin
      step("wrap_if", 1'b0, 1'b1, 1'b0, Fetch);
      step("wrap_id", 1'b0, 1'b1, 1'b0, SId | CPcw | CPcJ | CDone);
    end
    checks++;
    assert (instret === 4'd0) else begin
      fails++;
      $error("FAIL wrap_final instret: observed %0d expected 0", instret);
    end
    step("post_wrap", 1'b0, 1'b0, 1'b0, SIf | CMrd);

    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
